// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with inter-digit blanking,
// per-digit blink and decimal points. All outputs are registered.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_DIV    = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] code,
  input  logic [3:0] blink_en,
  input  logic [3:0] dp_en,
  output logic [1:0] scan,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_scan;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_slot_end;
  logic               w_blink_wrap;
  logic               w_in_blank;
  logic               w_hide;
  logic [6:0]         w_lit;

  // Segments lit per glyph code; bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] lit(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:    s = 7'h3F;
      5'd1:    s = 7'h06;
      5'd2:    s = 7'h5B;
      5'd3:    s = 7'h4F;
      5'd4:    s = 7'h66;
      5'd5:    s = 7'h6D;
      5'd6:    s = 7'h7D;
      5'd7:    s = 7'h07;
      5'd8:    s = 7'h7F;
      5'd9:    s = 7'h6F;
      5'd11:   s = 7'h38;
      5'd12:   s = 7'h5C;
      5'd13:   s = 7'h6D;
      5'd14:   s = 7'h78;
      5'd15:   s = 7'h73;
      5'd16:   s = 7'h77;
      5'd17:   s = 7'h50;
      5'd18:   s = 7'h1C;
      5'd19:   s = 7'h54;
      5'd20:   s = 7'h39;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign w_slot_end   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign w_lit        = lit(code);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      assign w_in_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  assign w_hide = w_in_blank | (blink_en[r_scan] & ~r_blink_phase);

  // Refresh counter and scan index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_scan <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt  <= '0;
      r_scan <= r_scan + 2'd1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Free-running blink timebase, independent of the refresh counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (w_blink_wrap) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Output stage uses pre-edge scan so anode and cathodes always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_hide) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_scan);
      r_seg <= ~w_lit;
      r_dp  <= ~dp_en[r_scan];
    end
  end

  assign scan = r_scan;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign an   = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: refresh order, glyphs, blank codes,
// blink, decimal point and mid-slot reset, with hand-derived expectations.
module tb_seg7_scan_driver;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned BDIV  = 20;

  logic       clk;
  logic       reset;
  logic [4:0] code;
  logic [3:0] blink_en;
  logic [3:0] dp_en;
  logic [1:0] scan;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  logic [4:0] tbl [4];
  int n_checks;
  int n_fail;

  seg7_scan_driver #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK),
    .BLINK_DIV   (BDIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .code    (code),
    .blink_en(blink_en),
    .dp_en   (dp_en),
    .scan    (scan),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display mux model: glyph code for the current scan index.
  always_comb code = tbl[scan];

  // Hand-computed lit-segment patterns (bit 0 = a ... bit 6 = g).
  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd4:    return 7'b1100110;   // b c f g
      5'd8:    return 7'b1111111;
      5'd11:   return 7'b0111000;   // L: d e f
      5'd12:   return 7'b1011100;   // o: c d e g
      5'd20:   return 7'b0111001;   // C: a d e f
      default: return 7'b0000000;   // codes 10, 25: blank
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: one reset edge, then outputs must be dark and scan 0.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_an"},   32'(an),   32'hF);
    check({tag, "_rst_seg"},  32'(seg),  32'h7F);
    check({tag, "_rst_dp"},   32'(dp),   32'h1);
    check({tag, "_rst_scan"}, 32'(scan), 32'h0);
    reset = 1'b0;
  endtask

  // After edge n following reset, outputs show the state before that edge:
  // cnt=(n-1)%8, scan=((n-1)/8)%4, blink hidden when ((n-1)/20) is odd.
  task automatic run_phase(input string tag, input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      int         pc;
      int         ps;
      logic       vis;
      logic       hide;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      @(posedge clk);
      @(negedge clk);
      pc   = (n - 1) % RDIV;
      ps   = ((n - 1) / RDIV) % 4;
      vis  = (((n - 1) / BDIV) % 2) == 0;
      hide = (pc < BLANK) || (blink_en[ps] && !vis);
      if (hide) begin
        e_an  = 4'b1111;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_an  = 4'b1111;
        e_an[ps] = 1'b0;
        e_seg = ~glyph(tbl[ps]);
        e_dp  = ~dp_en[ps];
      end
      check($sformatf("%s_an_c%0d", tag, n),   32'(an),   32'(e_an));
      check($sformatf("%s_seg_c%0d", tag, n),  32'(seg),  32'(e_seg));
      check($sformatf("%s_dp_c%0d", tag, n),   32'(dp),   32'(e_dp));
      check($sformatf("%s_scan_c%0d", tag, n), 32'(scan), 32'((n / RDIV) % 4));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    blink_en = 4'b0000;
    dp_en    = 4'b0000;
    tbl[0] = 5'd8; tbl[1] = 5'd8; tbl[2] = 5'd8; tbl[3] = 5'd8;
    repeat (2) @(posedge clk);
    @(negedge clk);

    apply_reset("eights");
    run_phase("eights", 40);

    tbl[0] = 5'd20; tbl[1] = 5'd12; tbl[2] = 5'd11; tbl[3] = 5'd20;
    apply_reset("cloc");
    run_phase("cloc", 32);

    tbl[0] = 5'd10; tbl[1] = 5'd25; tbl[2] = 5'd4; tbl[3] = 5'd8;
    apply_reset("blankcode");
    run_phase("blankcode", 32);

    tbl[0] = 5'd8; tbl[1] = 5'd8; tbl[2] = 5'd8; tbl[3] = 5'd8;
    blink_en = 4'b0001;
    apply_reset("blink");
    run_phase("blink", 96);

    blink_en = 4'b0000;
    dp_en    = 4'b0100;
    apply_reset("dp");
    run_phase("dp", 32);

    // Reset mid-slot at scan=2, cnt=5, then scanning restarts from digit 0.
    dp_en = 4'b0000;
    tbl[0] = 5'd4; tbl[1] = 5'd12; tbl[2] = 5'd20; tbl[3] = 5'd11;
    apply_reset("mid");
    run_phase("mid_pre", 21);
    check("mid_scan_before_reset", 32'(scan), 32'h2);
    apply_reset("mid");
    run_phase("mid_post", 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
